// File: rtl/aes_fifo_sequencer.sv
// aes_fifo_sequencer: moves 4-word blocks from the input FIFO through
// the AES core into the output FIFO, with a WAIT watchdog.
module aes_fifo_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic                  enable,
  input  logic                  key_valid,
  input  logic                  err_clr,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic [DATA_W-1:0]     in_rd_data,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_W-1:0]     out_wr_data,
  output logic                  aes_start,
  output logic [4*DATA_W-1:0]   aes_block_in,
  input  logic                  aes_done,
  input  logic [4*DATA_W-1:0]   aes_block_out,
  output logic                  busy,
  output logic                  error,
  output logic [15:0]           blk_count
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    STORE,
    ERR
  } state_t;

  state_t              st;
  state_t              nxt;
  logic [1:0]          widx;
  logic [1:0]          wsel;
  logic [CW-1:0]       wcnt;
  logic [4*DATA_W-1:0] blk;
  logic [4*DATA_W-1:0] res;
  logic                tmo;

  // word 0 lives in the top slice of both block registers
  assign wsel = 2'd3 - widx;
  assign tmo  = (wcnt == CW'(TIMEOUT));

  assign aes_block_in = blk;
  assign out_wr_data  = res[int'(wsel)*DATA_W +: DATA_W];
  assign busy         = (st != IDLE) && (st != ERR);
  assign error        = (st == ERR);

  // state register
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) st <= IDLE;
    else                  st <= nxt;
  end

  // next state and FIFO/core strobes
  always_comb begin
    nxt       = st;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    aes_start = 1'b0;
    unique case (st)
      IDLE: begin
        if (enable && key_valid && !in_empty) nxt = LOAD;
      end
      LOAD: begin
        in_rd_en = !in_empty;
        if (!in_empty && widx == 2'd3) nxt = START;
      end
      START: begin
        aes_start = 1'b1;
        nxt       = WAIT;
      end
      WAIT: begin
        if (aes_done) nxt = STORE;
        else if (tmo) nxt = ERR;
      end
      STORE: begin
        out_wr_en = !out_full;
        if (!out_full && widx == 2'd3) nxt = IDLE;
      end
      ERR: begin
        if (err_clr) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // word index, watchdog, block/result registers and block counter
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      widx      <= 2'd0;
      wcnt      <= '0;
      blk       <= '0;
      res       <= '0;
      blk_count <= 16'd0;
    end else begin
      if (st == IDLE && nxt == LOAD) widx <= 2'd0;
      if (in_rd_en) begin
        blk[int'(wsel)*DATA_W +: DATA_W] <= in_rd_data;
        widx <= widx + 2'd1;
      end
      if (aes_start) wcnt <= '0;
      if (st == WAIT) begin
        if (aes_done) begin
          res  <= aes_block_out;
          widx <= 2'd0;
        end else begin
          wcnt <= wcnt + CW'(1);
        end
      end
      if (out_wr_en) begin
        widx <= widx + 2'd1;
        if (widx == 2'd3) blk_count <= blk_count + 16'd1;
      end
    end
  end

endmodule
